// File: rtl/pool_pkg.sv
// Shared definitions for the stream_pooler CNN pooling stage.
package pool_pkg;

    localparam logic [1:0] POOL_MAX = 2'b00;
    localparam logic [1:0] POOL_AVG = 2'b01;
    localparam logic [1:0] POOL_MIN = 2'b10;
    localparam logic [1:0] POOL_SUM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Accumulator width: room for the sum of P*P N-bit pixels.
    function automatic int unsigned acc_w(input int unsigned n, input int unsigned p);
        return n + 2 * $clog2(p);
    endfunction

endpackage

// File: rtl/pool_combine.sv
// Combinational accumulator update: load on first pixel, else max/min/add.
module pool_combine
    import pool_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 18
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [N-1:0]     pix_i,
    input  logic [1:0]              pool_type_i,
    input  logic                    first_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [ACC_W-1:0] pix_ext;

    always_comb begin
        pix_ext = {{(ACC_W-N){pix_i[N-1]}}, pix_i};
        acc_o   = pix_ext;
        if (!first_i) begin
            case (pool_type_i)
                POOL_MAX: acc_o = (pix_ext > acc_i) ? pix_ext : acc_i;
                POOL_MIN: acc_o = (pix_ext < acc_i) ? pix_ext : acc_i;
                default:  acc_o = acc_i + pix_ext;
            endcase
        end
    end

endmodule

// File: rtl/stream_pooler.sv
// Streaming PxP stride-P pooling stage with one partial accumulator per window column.
// Optional build macro POOL_RELU_EN clamps every pooled result to max(result, 0).
module stream_pooler
    import pool_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned P     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   pool_type,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         busy,
    output logic         done
);

    localparam int unsigned LOG2P = $clog2(P);
    localparam int unsigned ACC_W = acc_w(N, P);
    localparam int unsigned NACC  = IMG_W / P;
    localparam int unsigned IW    = (NACC > 1) ? $clog2(NACC) : 1;
    localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned SH    = 2 * LOG2P;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    if ((P < 2) || ((P & (P - 1)) != 0)) begin : g_bad_p
        $error("stream_pooler: P must be a power of 2 and >= 2");
    end
    if ((IMG_W % P) != 0) begin : g_bad_w
        $error("stream_pooler: IMG_W must be a multiple of P");
    end
    if ((IMG_H % P) != 0) begin : g_bad_h
        $error("stream_pooler: IMG_H must be a multiple of P");
    end

    state_e                  state_q, state_d;
    logic [1:0]              type_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic signed [ACC_W-1:0] acc_q [NACC];
    logic                    m_valid_q;
    logic [N-1:0]            m_data_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    pix_acc;
    logic                    win_first;
    logic                    win_last;
    logic                    col_last;
    logic                    row_last;
    logic [IW-1:0]           acc_idx;
    logic signed [ACC_W-1:0] comb_acc;
    logic signed [ACC_W-1:0] avg_acc;
    logic [N-1:0]            res;

    assign s_ready = (state_q == ST_RUN) && (!m_valid_q || m_ready);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

    assign pix_acc   = s_valid && s_ready;
    assign col_last  = (col_q == CW'(IMG_W - 1));
    assign row_last  = (row_q == RW'(IMG_H - 1));
    assign acc_idx   = IW'(col_q >> LOG2P);
    assign win_first = (row_q[LOG2P-1:0] == '0) && (col_q[LOG2P-1:0] == '0);
    assign win_last  = (&row_q[LOG2P-1:0]) && (&col_q[LOG2P-1:0]);

    pool_combine #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_combine (
        .acc_i       (acc_q[acc_idx]),
        .pix_i       (s_data),
        .pool_type_i (type_q),
        .first_i     (win_first),
        .acc_o       (comb_acc)
    );

    // Window post-processing: avg shift, sum saturation, optional ReLU.
    always_comb begin
        avg_acc = comb_acc >>> SH;
        res     = N'(comb_acc);
        case (type_q)
            POOL_AVG: res = N'(avg_acc);
            POOL_SUM: begin
                if (comb_acc > SAT_MAX)      res = N'(SAT_MAX);
                else if (comb_acc < SAT_MIN) res = N'(SAT_MIN);
                else                         res = N'(comb_acc);
            end
            default: res = N'(comb_acc);
        endcase
`ifdef POOL_RELU_EN
        if (res[N-1]) res = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (pix_acc && col_last && row_last) state_d = ST_DRAIN;
            ST_DRAIN: if (m_valid_q && m_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q    <= POOL_MAX;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < int'(NACC); i++) acc_q[i] <= '0;
        end else begin
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
            if ((state_q == ST_IDLE) && start) begin
                type_q <= pool_type;
                col_q  <= '0;
                row_q  <= '0;
            end
            if (pix_acc) begin
                acc_q[acc_idx] <= comb_acc;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            // s_ready guarantees the slot is free or being drained this cycle.
            if (pix_acc && win_last) begin
                m_valid_q <= 1'b1;
                m_data_q  <= res;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_pooler.sv
// Scoreboard bench for stream_pooler on a 4x4 frame with 2x2 windows.
module tb_stream_pooler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pool_type = 2'b00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q [$];
    logic signed [15:0] pix [16];

    stream_pooler #(
        .N     (16),
        .IMG_W (4),
        .IMG_H (4),
        .P     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pool_type (pool_type),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [1:0] t, input int a, input int b,
                                          input int c, input int d);
        int s;
        int r;
        s = a + b + c + d;
        case (t)
            2'd0: begin r = a; if (b > r) r = b; if (c > r) r = c; if (d > r) r = d; end
            2'd1: r = (s - (((s % 4) + 4) % 4)) / 4;
            2'd2: begin r = a; if (b < r) r = b; if (c < r) r = c; if (d < r) r = d; end
            default: r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        endcase
`ifdef POOL_RELU_EN
        if (r < 0) r = 0;
`endif
        return 16'(r);
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) pix[i] = 16'(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_ready"}, 32'(s_ready), 0);
        check_eq({tag, "_m_valid"}, 32'(m_valid), 0);
        check_eq({tag, "_m_data"},  32'(m_data),  0);
        check_eq({tag, "_busy"},    32'(busy),    0);
        check_eq({tag, "_done"},    32'(done),    0);
    endtask

    task automatic run_frame(input logic [1:0] t, input bit stall, input bit toggle);
        int pi;
        int outs;
        int cyc;
        int stall_left;
        @(posedge clk); #1;
        start = 1'b1;
        pool_type = t;
        @(posedge clk); #1;
        start = 1'b0;
        if (toggle) pool_type = ~t;
        check_eq("busy_after_start", 32'(busy), 1);
        pi = 0; outs = 0; cyc = 0;
        stall_left = stall ? 5 : 0;
        while (outs < 4 && cyc < 400) begin
            s_valid = (pi < 16);
            s_data  = (pi < 16) ? pix[pi] : 16'h0;
            m_ready = !(stall_left > 0 && m_valid);
            start   = toggle && (pi == 5);
            @(negedge clk);
            if (!m_ready) begin
                check_eq("hold_valid", 32'(m_valid), 1);
                check_eq("hold_s_ready", 32'(s_ready), 0);
                if (exp_q.size() == 0) check_eq("hold_queue", 0, 1);
                else                   check_eq("hold_data", 32'(m_data), 32'(exp_q[0]));
                stall_left--;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_output", 32'(m_data), 32'hdead);
                else                   check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
                outs++;
            end
            if (s_valid && s_ready) begin
                if ((pi % 8) >= 4 && (pi % 2) == 1)
                    exp_q.push_back(model(t, int'(pix[pi-5]), int'(pix[pi-4]),
                                          int'(pix[pi-1]), int'(pix[pi])));
                pi++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        m_ready = 1'b1;
        check_eq("frame_timeout", 32'(cyc < 400), 1);
        check_eq("pixels_taken", 32'(pi), 16);
        check_eq("done_pulse", 32'(done), 1);
        @(posedge clk); #1;
        check_eq("done_low", 32'(done), 0);
        check_eq("busy_idle", 32'(busy), 0);
    endtask

    task automatic abort_frame();
        int pi;
        int cyc;
        @(posedge clk); #1;
        start = 1'b1;
        pool_type = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        pi = 0; cyc = 0;
        while (pi < 6 && cyc < 100) begin
            s_valid = 1'b1;
            s_data  = 16'h7000;
            m_ready = 1'b1;
            @(negedge clk);
            if (s_valid && s_ready) pi++;
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("abort_timeout", 32'(cyc < 100), 1);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #3;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        load_ramp();
        for (int t = 0; t < 4; t++) run_frame(2'(t), 1'b0, 1'b0);

        pix[0] = -16'sd1; pix[1] = -16'sd2; pix[4] = -16'sd3; pix[5] = -16'sd4;
        run_frame(2'd1, 1'b0, 1'b0);
        run_frame(2'd0, 1'b0, 1'b0);

        foreach (pix[i]) pix[i] = 16'sd1000;
        pix[0] = 16'sh7fff; pix[1] = 16'sh7fff; pix[4] = 16'sh7fff; pix[5] = 16'sh7fff;
        pix[2] = 16'sh8000; pix[3] = 16'sh8000; pix[6] = 16'sh8000; pix[7] = 16'sh8000;
        pix[8] = 16'sh7fff; pix[9] = -16'sd1;   pix[12] = 16'sh8000; pix[13] = 16'sd5;
        for (int t = 0; t < 4; t++) run_frame(2'(t), 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            foreach (pix[i]) pix[i] = 16'($urandom);
            run_frame(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        load_ramp();
        run_frame(2'd0, 1'b1, 1'b0);

        abort_frame();
        load_ramp();
        run_frame(2'd0, 1'b0, 1'b0);

        run_frame(2'd1, 1'b0, 1'b1);
        run_frame(2'd2, 1'b1, 1'b1);

        check_eq("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
